// File: rtl/trace_req_sequencer_if.sv
// Request handshake between the trace sequencer (master) and the cache
// controller (slave). A record transfers on req_valid & req_ready.
interface trace_req_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;

    modport master (
        output req_valid,
        output req_write,
        output req_addr,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_addr,
        output req_ready
    );
endinterface

// File: rtl/trace_req_sequencer.sv
// trace_req_sequencer: parses ASCII trace lines ("<op> <hex addr>\n") from an
// SD file reader byte stream into read/write records, buffers them in a
// 2^FIFO_AW entry FIFO and presents them on a valid/ready request interface.
// Optional statistics counters are built when TRACE_REQ_STATS_EN is defined;
// otherwise the counter ports are tied to zero.
module trace_req_sequencer #(
    parameter int ADDR_W  = 32,
    parameter int FIFO_AW = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_en,
    input  logic [7:0]             in_byte,
    input  logic                   in_flush,
    trace_req_sequencer_if.master  req,
    output logic [FIFO_AW:0]       fifo_level,
    output logic                   ovf,
    input  logic                   ovf_clr,
    output logic                   err_pulse,
    output logic [31:0]            rec_cnt,
    output logic [15:0]            drop_cnt,
    output logic [15:0]            err_cnt
);

    localparam int MAXD  = ADDR_W / 4;
    localparam int CNT_W = $clog2(MAXD + 1);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_LVL = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [1:0] {
        LINE_START,
        SEP,
        ADDR,
        SKIP
    } state_t;

    state_t              st_q, st_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic                sep_q, sep_d;
    logic                trail_q, trail_d;
    logic                err_q, err_d;
    logic                push_d;

    // Staged record: written into the FIFO one edge after the terminating byte
    logic                push_q;
    logic [ADDR_W-1:0]   rec_addr_q;
    logic                rec_wr_q;

    // Byte classification
    logic       is_lf, is_cr, is_ws, op_rd, op_wr, hex_ok;
    logic [3:0] hex_val;

    // Classify the incoming byte
    always_comb begin
        is_lf   = (in_byte == 8'h0A);
        is_cr   = (in_byte == 8'h0D);
        is_ws   = (in_byte == 8'h20) || (in_byte == 8'h09);
        op_rd   = (in_byte == 8'h52) || (in_byte == 8'h72) || (in_byte == 8'h30);
        op_wr   = (in_byte == 8'h57) || (in_byte == 8'h77) || (in_byte == 8'h31);
        hex_ok  = 1'b0;
        hex_val = 4'd0;
        if (in_byte >= 8'h30 && in_byte <= 8'h39) begin
            hex_ok  = 1'b1;
            hex_val = in_byte[3:0];
        end else if ((in_byte >= 8'h61 && in_byte <= 8'h66) ||
                     (in_byte >= 8'h41 && in_byte <= 8'h46)) begin
            hex_ok  = 1'b1;
            hex_val = in_byte[3:0] + 4'd9;
        end
    end

    // Parser next state: the byte is applied first, then any same-cycle flush
    always_comb begin
        st_d    = st_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        sep_d   = sep_q;
        trail_d = trail_q;
        err_d   = 1'b0;
        push_d  = 1'b0;

        if (in_en && !is_cr) begin
            unique case (st_q)
                LINE_START: begin
                    if (is_ws || is_lf) begin
                        st_d = LINE_START;
                    end else if (op_rd || op_wr) begin
                        wr_d  = op_wr;
                        sep_d = 1'b0;
                        st_d  = SEP;
                    end else begin
                        err_d = 1'b1;
                        st_d  = SKIP;
                    end
                end
                SEP: begin
                    if (is_ws) begin
                        sep_d = 1'b1;
                    end else if (hex_ok && sep_q) begin
                        addr_d  = {{(ADDR_W-4){1'b0}}, hex_val};
                        cnt_d   = CNT_W'(1);
                        trail_d = 1'b0;
                        st_d    = ADDR;
                    end else if (is_lf) begin
                        err_d = 1'b1;
                        st_d  = LINE_START;
                    end else begin
                        err_d = 1'b1;
                        st_d  = SKIP;
                    end
                end
                ADDR: begin
                    // A digit after trailing whitespace is malformed
                    if (hex_ok && !trail_q) begin
                        if (cnt_q == CNT_W'(MAXD)) begin
                            err_d = 1'b1;
                            st_d  = SKIP;
                        end else begin
                            addr_d = {addr_q[ADDR_W-5:0], hex_val};
                            cnt_d  = cnt_q + CNT_W'(1);
                        end
                    end else if (is_ws) begin
                        trail_d = 1'b1;
                    end else if (is_lf) begin
                        push_d = 1'b1;
                        st_d   = LINE_START;
                    end else begin
                        err_d = 1'b1;
                        st_d  = SKIP;
                    end
                end
                SKIP: begin
                    if (is_lf) st_d = LINE_START;
                end
                default: st_d = LINE_START;
            endcase
        end

        // ADDR always holds at least one digit, so a flush there completes the line
        if (in_flush) begin
            if (st_d == ADDR) push_d = 1'b1;
            st_d = LINE_START;
        end
    end

    // Parser registers and record staging
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q       <= LINE_START;
            addr_q     <= '0;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            sep_q      <= 1'b0;
            trail_q    <= 1'b0;
            err_q      <= 1'b0;
            push_q     <= 1'b0;
            rec_addr_q <= '0;
            rec_wr_q   <= 1'b0;
        end else begin
            st_q       <= st_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            sep_q      <= sep_d;
            trail_q    <= trail_d;
            err_q      <= err_d;
            push_q     <= push_d;
            rec_addr_q <= addr_d;
            rec_wr_q   <= wr_d;
        end
    end

    // Record FIFO
    logic [ADDR_W-1:0]  mem_addr [DEPTH];
    logic               mem_wr   [DEPTH];
    logic [FIFO_AW-1:0] wptr_q, rptr_q;
    logic [FIFO_AW:0]   level_q, level_d;
    logic               ovf_q;
    logic               pop, full, fifo_we, drop;

    // When full, a simultaneous pop frees the head slot that wptr now points at
    always_comb begin
        pop     = (level_q != '0) && req.req_ready;
        full    = (level_q == FULL_LVL);
        fifo_we = push_q && (!full || pop);
        drop    = push_q && full && !pop;
        level_d = level_q;
        if (fifo_we && !pop)      level_d = level_q + 1'b1;
        else if (!fifo_we && pop) level_d = level_q - 1'b1;
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (fifo_we) begin
            mem_addr[wptr_q] <= rec_addr_q;
            mem_wr[wptr_q]   <= rec_wr_q;
        end
    end

    // FIFO pointers, level and sticky overflow (a new overflow beats ovf_clr)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (fifo_we) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
            level_q <= level_d;
            if (drop)         ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

    assign req.req_valid = (level_q != '0);
    assign req.req_write = req.req_valid ? mem_wr[rptr_q]   : 1'b0;
    assign req.req_addr  = req.req_valid ? mem_addr[rptr_q] : '0;
    assign fifo_level    = level_q;
    assign ovf           = ovf_q;
    assign err_pulse     = err_q;

`ifdef TRACE_REQ_STATS_EN
    logic [31:0] rec_cnt_q;
    logic [15:0] drop_cnt_q, err_cnt_q;

    // Saturating statistics counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rec_cnt_q  <= '0;
            drop_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (fifo_we && rec_cnt_q != '1)  rec_cnt_q  <= rec_cnt_q + 1'b1;
            if (drop && drop_cnt_q != '1)    drop_cnt_q <= drop_cnt_q + 1'b1;
            if (err_q && err_cnt_q != '1)    err_cnt_q  <= err_cnt_q + 1'b1;
        end
    end

    assign rec_cnt  = rec_cnt_q;
    assign drop_cnt = drop_cnt_q;
    assign err_cnt  = err_cnt_q;
`else
    assign rec_cnt  = '0;
    assign drop_cnt = '0;
    assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_trace_req_sequencer.sv
// Scoreboard bench for trace_req_sequencer: directed trace lines push their
// expected records into a queue; a monitor pops and compares on each transfer.
module tb_trace_req_sequencer;

    localparam int ADDR_W  = 32;
    localparam int FIFO_AW = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_en = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_flush = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [FIFO_AW:0] fifo_level;
    logic        ovf, err_pulse;
    logic [31:0] rec_cnt;
    logic [15:0] drop_cnt, err_cnt;

    trace_req_sequencer_if #(.ADDR_W(ADDR_W)) rif ();

    trace_req_sequencer #(.ADDR_W(ADDR_W), .FIFO_AW(FIFO_AW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_en      (in_en),
        .in_byte    (in_byte),
        .in_flush   (in_flush),
        .req        (rif.master),
        .fifo_level (fifo_level),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr),
        .err_pulse  (err_pulse),
        .rec_cnt    (rec_cnt),
        .drop_cnt   (drop_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int err_seen = 0;
    logic [ADDR_W:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: compare every transfer with the scoreboard head; count error pulses
    always @(negedge clk) begin
        if (rstn) begin
            if (err_pulse) err_seen++;
            if (rif.req_valid && rif.req_ready) begin
                logic [ADDR_W:0] e;
                logic [ADDR_W:0] a;
                a = {rif.req_write, rif.req_addr};
                if (exp_q.size() == 0) begin
                    chk("unexpected_rec", a, '1);
                end else begin
                    e = exp_q.pop_front();
                    chk("rec", a, e);
                end
            end
        end
    end

    task automatic expect_rec(input logic w, input logic [ADDR_W-1:0] a);
        exp_q.push_back({w, a});
    endtask

    task automatic send_str(input string s, input bit flush_last);
        for (int i = 0; i < s.len(); i++) begin
            in_en    = 1'b1;
            in_byte  = s[i];
            in_flush = flush_last && (i == s.len() - 1);
            @(posedge clk); #1;
            in_en    = 1'b0;
            in_flush = 1'b0;
        end
    endtask

    task automatic pulse_flush();
        in_flush = 1'b1;
        @(posedge clk); #1;
        in_flush = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        idle(2);
        while ((exp_q.size() != 0 || fifo_level != '0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_timeout", 64'(exp_q.size()), 0);
    endtask

    task automatic check_stats(input string tag, input int rc, input int dc, input int ec);
`ifdef TRACE_REQ_STATS_EN
        chk({tag, "_rec_cnt"},  rec_cnt,  64'(rc));
        chk({tag, "_drop_cnt"}, drop_cnt, 64'(dc));
        chk({tag, "_err_cnt"},  err_cnt,  64'(ec));
`else
        chk({tag, "_stats_off"}, {rec_cnt, drop_cnt, err_cnt}, 0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        rif.req_ready = 1'b1;

        // Reset state
        #23;
        chk("rst_valid", rif.req_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf_err", {ovf, err_pulse}, 0);
        chk("rst_req", {rif.req_write, rif.req_addr}, 0);
        @(negedge clk); rstn = 1'b1;
        idle(2);

        // Basic read with latency check: LF at edge k, valid after edge k+1
        expect_rec(1'b0, 32'h1A2B3C4D);
        send_str("R 1a2b3c4d\n", 1'b0);
        @(negedge clk);
        chk("lat_k", rif.req_valid, 0);
        @(negedge clk);
        chk("lat_k1", rif.req_valid, 1);
        wait_drain();

        // Write with tab/CR, then two malformed lines
        e0 = err_seen;
        expect_rec(1'b1, 32'h10);
        send_str("w\t00000010\r\n", 1'b0);
        send_str("X 5\n", 1'b0);
        send_str("W\n", 1'b0);
        wait_drain();
        chk("err_two", 64'(err_seen - e0), 2);
        check_stats("s1", 2, 0, 2);

        // Exact error pulse timing
        send_str("Q", 1'b0);
        @(negedge clk);
        chk("errpulse_hi", err_pulse, 1);
        @(negedge clk);
        chk("errpulse_lo", err_pulse, 0);
        send_str("\n", 1'b0);

        // Too many digits, digit without separator, digit after trailing space
        e0 = err_seen;
        send_str("R 123456789\n", 1'b0);
        send_str("R5\n", 1'b0);
        send_str("W 1 2\n", 1'b0);
        idle(3);
        chk("err_three", 64'(err_seen - e0), 3);
        chk("err_norec", fifo_level, 0);

        // Accepted forms: blank line, leading ws, trailing ws, op digits, 8 digits
        e0 = err_seen;
        expect_rec(1'b1, 32'h7F);
        expect_rec(1'b0, 32'h0);
        expect_rec(1'b0, 32'hFFFFFFFF);
        expect_rec(1'b0, 32'hABC);
        expect_rec(1'b1, 32'h5);
        send_str("\n  1 \t7f  \n", 1'b0);
        send_str("r 0\n", 1'b0);
        send_str("0 FFFFFFFF\n", 1'b0);
        send_str("R abc", 1'b0);
        pulse_flush();
        send_str("W 5", 1'b1);
        send_str("R ", 1'b0);
        pulse_flush();
        wait_drain();
        chk("ok_noerr", 64'(err_seen - e0), 0);

        // Empty pop has no effect
        chk("empty_level", fifo_level, 0);

        // Reset mid-address
        send_str("R 12", 1'b0);
        rstn = 1'b0;
        #3;
        chk("midrst_outs", {rif.req_valid, fifo_level, ovf, err_pulse}, 0);
        check_stats("rst", 0, 0, 0);
        @(negedge clk); rstn = 1'b1;
        idle(1);
        expect_rec(1'b1, 32'hFF);
        send_str("W ff\n", 1'b0);
        wait_drain();

        // Overflow: 17 lines with no acceptance
        rif.req_ready = 1'b0;
        for (int n = 1; n <= 17; n++) begin
            if (n <= 16) expect_rec(1'b1, ADDR_W'(n));
            send_str($sformatf("W %0h\n", n), 1'b0);
        end
        idle(2);
        chk("ovf_level", fifo_level, 16);
        chk("ovf_set", ovf, 1);
        check_stats("ovf", 17, 1, 0);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        chk("ovf_clr", ovf, 0);

        // Full: push and pop on the same edge
        expect_rec(1'b0, 32'h99);
        send_str("R 99\n", 1'b0);
        rif.req_ready = 1'b1;
        @(posedge clk); #1;
        rif.req_ready = 1'b0;
        @(negedge clk);
        chk("full_pp_level", fifo_level, 16);
        chk("full_pp_ovf", ovf, 0);
        check_stats("pp", 18, 1, 0);
        rif.req_ready = 1'b1;
        wait_drain();
        chk("drained_level", fifo_level, 0);

        // Overflow coinciding with ovf_clr keeps ovf set
        rif.req_ready = 1'b0;
        for (int n = 0; n < 16; n++) begin
            expect_rec(1'b0, ADDR_W'(n + 32'h100));
            send_str($sformatf("r %0h\n", n + 32'h100), 1'b0);
        end
        send_str("w 2\n", 1'b0);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        chk("ovf_prio", ovf, 1);
        check_stats("prio", 34, 2, 0);
        rif.req_ready = 1'b1;
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
